// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared definitions for the multiply/divide unit.
// Holds the md_op encodings, default busy latencies and the FSM state type.
// Used by the decoder, the hazard unit and md_unit itself.
package md_unit_pkg;

  localparam int DATA_W         = 32;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // True for the four operations that occupy the unit for several cycles.
  function automatic logic is_long_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage bus between the pipeline and the multiply/divide unit.
//   start, md_op, A, B : operation request and forwarded rs/rt operands
//   use_md_D           : D-stage instruction touches the unit or HI/LO
//   busy, stall_md     : progress flag and interlock request back to the pipeline
//   HI, LO             : architectural HI/LO registers
// master = pipeline side, slave = md_unit side.
interface md_unit_if;
  import md_unit_pkg::*;

  logic              start;
  logic [2:0]        md_op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              use_md_D;
  logic              busy;
  logic              stall_md;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output start, md_op, A, B, use_md_D,
    input  busy, stall_md, HI, LO
  );

  modport slave (
    input  start, md_op, A, B, use_md_D,
    output busy, stall_md, HI, LO
  );

endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO.
//   clk   : system clock, all state updates on posedge
//   reset : synchronous, active-high; clears HI, LO and busy state
//   bus   : md_unit_if.slave (start/md_op/A/B/use_md_D in; busy/stall_md/HI/LO out)
// The result is computed in the start cycle and held in res_q; HI/LO only
// change when the busy count expires, so they keep their old values while busy.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  md_state_e             state_q;
  logic [3:0]            cnt_q;
  logic                  busy_q;
  logic                  skip_q;
  logic [2*DATA_W-1:0]   res_q;
  logic [2*DATA_W-1:0]   res_d;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;
  md_op_e                op_in;

  // 64-bit HI:LO result of a long op. Divisor is forced to 1 when zero so the
  // arithmetic stays defined; that result is discarded via skip_q anyway.
  // Dividing on 64-bit extended operands makes 0x80000000 / -1 wrap cleanly.
  function automatic logic [2*DATA_W-1:0] md_compute(md_op_e op,
                                                     logic [DATA_W-1:0] a,
                                                     logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] a_s, b_s, b_sd;
    logic        [2*DATA_W-1:0] a_u, b_u, b_ud;
    logic signed [DATA_W-1:0]   q_s, r_s;
    logic        [DATA_W-1:0]   q_u, r_u;
    logic        [2*DATA_W-1:0] res;
    a_s  = {{DATA_W{a[DATA_W-1]}}, a};
    b_s  = {{DATA_W{b[DATA_W-1]}}, b};
    a_u  = {{DATA_W{1'b0}}, a};
    b_u  = {{DATA_W{1'b0}}, b};
    b_sd = (b == '0) ? 64'sd1 : b_s;
    b_ud = (b == '0) ? 64'd1  : b_u;
    q_s  = DATA_W'(a_s / b_sd);
    r_s  = DATA_W'(a_s % b_sd);
    q_u  = DATA_W'(a_u / b_ud);
    r_u  = DATA_W'(a_u % b_ud);
    case (op)
      MD_MULT:  res = a_s * b_s;
      MD_MULTU: res = a_u * b_u;
      MD_DIV:   res = {r_s, q_s};
      MD_DIVU:  res = {r_u, q_u};
      default:  res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    op_in = md_op_e'(bus.md_op);
    res_d = md_compute(op_in, bus.A, bus.B);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      skip_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && is_long_op(op_in)) begin
            res_q   <= res_d;
            skip_q  <= ((op_in == MD_DIV) || (op_in == MD_DIVU)) && (bus.B == '0);
            cnt_q   <= ((op_in == MD_MULT) || (op_in == MD_MULTU)) ? MULT_LAT : DIV_LAT;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else if (op_in == MD_MTHI) begin
            hi_q <= bus.A;
          end else if (op_in == MD_MTLO) begin
            lo_q <= bus.A;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (!skip_q) begin
              hi_q <= res_q[2*DATA_W-1:DATA_W];
              lo_q <= res_q[DATA_W-1:0];
            end
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The interlock covers the start cycle too, before busy has risen.
  assign bus.stall_md = bus.use_md_D & (bus.start | busy_q);
  assign bus.busy     = busy_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit with a cycle-level reference model.
module tb_md_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: remaining busy cycles plus the pending HI/LO result.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_rem = 0;
  bit          p_vld = 1'b0;

  always @(posedge clk) begin
    longint          sa, sb, sp, sq;
    longint unsigned up;
    logic [31:0]     uq;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; p_vld = 1'b0;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
      if (m_rem == 0 && p_vld) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (bus.start && bus.md_op >= 3'd1 && bus.md_op <= 3'd4) begin
      sa = longint'($signed(bus.A));
      sb = longint'($signed(bus.B));
      p_vld = 1'b1;
      case (bus.md_op)
        3'd1: begin sp = sa * sb; p_hi = sp[63:32]; p_lo = sp[31:0]; m_rem = 5; end
        3'd2: begin up = 64'(bus.A) * 64'(bus.B); p_hi = up[63:32]; p_lo = up[31:0]; m_rem = 5; end
        3'd3: begin
          m_rem = 10;
          if (bus.B == 0) p_vld = 1'b0;
          else begin sq = sa / sb; sp = sa - sq * sb; p_lo = sq[31:0]; p_hi = sp[31:0]; end
        end
        default: begin
          m_rem = 10;
          if (bus.B == 0) p_vld = 1'b0;
          else begin uq = bus.A / bus.B; p_lo = uq; p_hi = bus.A - uq * bus.B; end
        end
      endcase
    end else if (bus.md_op == 3'd5) begin
      m_hi = bus.A;
    end else if (bus.md_op == 3'd6) begin
      m_lo = bus.A;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Every cycle: outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  32'(bus.busy), 32'(m_rem > 0));
      chk("stall", 32'(bus.stall_md), 32'(bus.use_md_D & (bus.start | (m_rem > 0))));
      chk("HI",    bus.HI, m_hi);
      chk("LO",    bus.LO, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.md_op = 3'd0; bus.A = '0; bus.B = '0;
  endtask

  // Issue one long op, count busy cycles, check against the expected latency.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input int exp_n);
    int n;
    bus.start = 1'b1; bus.md_op = op; bus.A = a; bus.B = b; bus.use_md_D = use_d;
    #1;
    chk("stall_start", 32'(bus.stall_md), 32'(use_d));
    tick();
    idle_inputs();
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      tick();
    end
    if (n >= 40) chk("busy_timeout", 32'(n), 32'(exp_n));
    chk("busy_len", 32'(n), 32'(exp_n));
    bus.use_md_D = 1'b0;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    bus.md_op = op; bus.A = a;
    tick();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    bus.use_md_D = 1'b0;
    idle_inputs();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_HI", bus.HI, 32'h0);
    chk("rst_LO", bus.LO, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b1, 5);
    chk("mult_HI", bus.HI, 32'hFFFFFFFF);
    chk("mult_LO", bus.LO, 32'hFFFFFFF1);
    chk("model_mult_LO", m_lo, 32'hFFFFFFF1);

    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 5);
    chk("multu_HI", bus.HI, 32'h00000001);
    chk("multu_LO", bus.LO, 32'hFFFFFFFE);

    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 10);
    chk("div_LO", bus.LO, 32'hFFFFFFFD);
    chk("div_HI", bus.HI, 32'hFFFFFFFF);
    chk("model_div_HI", m_hi, 32'hFFFFFFFF);

    run_op(3'd4, 32'd7, 32'd2, 1'b0, 10);
    chk("divu_LO", bus.LO, 32'd3);
    chk("divu_HI", bus.HI, 32'd1);

    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 10);
    chk("div_negb_LO", bus.LO, 32'hFFFFFFFD);
    chk("div_negb_HI", bus.HI, 32'd1);

    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10);
    chk("div_ovf_LO", bus.LO, 32'h80000000);
    chk("div_ovf_HI", bus.HI, 32'h0);

    mt(3'd5, 32'h11);
    chk("mthi", bus.HI, 32'h11);
    mt(3'd6, 32'h22);
    chk("mtlo", bus.LO, 32'h22);
    chk("mtlo_busy", 32'(bus.busy), 32'h0);

    run_op(3'd3, 32'd5, 32'd0, 1'b1, 10);
    chk("div0_HI", bus.HI, 32'h11);
    chk("div0_LO", bus.LO, 32'h22);

    // Reserved op with start must not occupy the unit.
    bus.start = 1'b1; bus.md_op = 3'd7; bus.A = 32'h5; bus.B = 32'h3;
    tick();
    idle_inputs();
    chk("rsvd_busy", 32'(bus.busy), 32'h0);

    // MTHI and a second start while busy are both ignored.
    bus.start = 1'b1; bus.md_op = 3'd2; bus.A = 32'd3; bus.B = 32'd4;
    tick();
    bus.start = 1'b0; bus.md_op = 3'd5; bus.A = 32'hDEAD;
    tick();
    bus.start = 1'b1; bus.md_op = 3'd4; bus.A = 32'd9; bus.B = 32'd2;
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("busy_ign_HI", bus.HI, 32'h0);
    chk("busy_ign_LO", bus.LO, 32'd12);
    chk("busy_ign_done", 32'(bus.busy), 32'h0);

    // Reset in cycle T+3 of a DIV aborts it for good.
    bus.start = 1'b1; bus.md_op = 3'd4; bus.A = 32'd100; bus.B = 32'd7;
    tick();
    idle_inputs();
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_HI", bus.HI, 32'h0);
    chk("abort_LO", bus.LO, 32'h0);
    repeat (12) tick();
    chk("abort_late_LO", bus.LO, 32'h0);

    // Reset and start together: reset wins.
    mt(3'd6, 32'h77);
    reset = 1'b1; bus.start = 1'b1; bus.md_op = 3'd1; bus.A = 32'd2; bus.B = 32'd3;
    tick();
    reset = 1'b0;
    idle_inputs();
    chk("rst_start_busy", 32'(bus.busy), 32'h0);
    chk("rst_start_LO", bus.LO, 32'h0);
    repeat (6) tick();
    chk("rst_start_late_LO", bus.LO, 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
